// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad encoder slice.
// Button indices 0-15 are hex keys; 16-19 are the control keys.
package keypad_pkg;

  localparam int NUM_KEYS = 20;
  localparam int HEX_KEYS = 16;

  typedef logic [4:0] key_code_t;

  localparam key_code_t KEY_ENTER = 5'd16;
  localparam key_code_t KEY_BACK  = 5'd17;
  localparam key_code_t KEY_MODE  = 5'd18;
  localparam key_code_t KEY_RUN   = 5'd19;

  // Index of the lowest set bit; zero when nothing is set.
  function automatic key_code_t lowest_key(input logic [NUM_KEYS-1:0] vec);
    key_code_t code;
    code = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (vec[i]) code = key_code_t'(i);
    end
    return code;
  endfunction

endpackage

// File: rtl/keypad_fifo.sv
// Small synchronous FIFO holding key events for the consumer.
// A write into a full FIFO is taken only when a read happens in the same
// cycle; head reads as zero while the FIFO is empty.
module keypad_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign head  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer bookkeeping; reset empties the queue immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage array, written at the tail slot.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/keypad_encoder.sv
// Keypad encoder: synchronizes and debounces 20 push-buttons, turns press
// edges into key codes and queues them for the consumer.
// Optional feature: define KEYPAD_AUTOREPEAT_EN to auto-repeat a hex key
// that is held on its own.
module keypad_encoder
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int FIFO_DEPTH      = 4,
  parameter int REPEAT_DELAY    = 50,
  parameter int REPEAT_RATE     = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] pb,
  output logic                key_valid,
  output key_code_t           key_code,
  input  logic                key_ready,
  output logic                key_held,
  output logic                overflow,
  input  logic                ovf_clr
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [NUM_KEYS-1:0] sync1;
  logic [NUM_KEYS-1:0] sync2;
  logic [NUM_KEYS-1:0] sample;
  logic [NUM_KEYS-1:0] deb;
  logic [NUM_KEYS-1:0] deb_next;
  logic [NUM_KEYS-1:0] deb_prev;
  logic [NUM_KEYS-1:0] rise;
  logic [NUM_KEYS-1:0] events;
  logic [CW-1:0]       tick_cnt;
  logic                tick;
  logic                push;
  logic                pop;
  logic                full;
  logic                empty;
  logic                drop;
  key_code_t           push_code;

  // Two-flop synchronizer on every raw button.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= pb;
      sync2 <= sync1;
    end
  end

  assign tick = (tick_cnt == CW'(DEBOUNCE_CYCLES - 1));

  // Shared sample-tick divider.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else tick_cnt <= tick_cnt + 1'b1;
  end

  // A bit follows its input only when this tick's sample matches the last one.
  always_comb begin
    deb_next = deb;
    if (tick) deb_next = (~(sync2 ^ sample) & sync2) | ((sync2 ^ sample) & deb);
  end

  // Debounce state, plus a one-cycle-old copy for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample   <= '0;
      deb      <= '0;
      deb_prev <= '0;
    end else begin
      if (tick) sample <= sync2;
      deb      <= deb_next;
      deb_prev <= deb;
    end
  end

  assign rise     = deb & ~deb_prev;
  assign key_held = |deb;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW      = $clog2(REP_MAX + 1);

  logic [RW-1:0] rep_cnt;
  logic [RW-1:0] rep_inc;
  logic [RW-1:0] rep_limit;
  logic          rep_mode;
  logic          rep_fire;
  logic          single_hex;

  assign single_hex = (deb[NUM_KEYS-1:KEY_ENTER] == '0) && $onehot(deb[HEX_KEYS-1:0]);
  assign rep_inc    = rep_cnt + 1'b1;
  assign rep_limit  = rep_mode ? RW'(REPEAT_RATE) : RW'(REPEAT_DELAY);

  // Repeat timer counts ticks while one hex key is held alone; any change restarts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_cnt  <= '0;
      rep_mode <= 1'b0;
      rep_fire <= 1'b0;
    end else begin
      rep_fire <= 1'b0;
      if (tick) begin
        if ((deb_next != deb) || !single_hex) begin
          rep_cnt  <= '0;
          rep_mode <= 1'b0;
        end else if (rep_inc == rep_limit) begin
          rep_cnt  <= '0;
          rep_mode <= 1'b1;
          rep_fire <= 1'b1;
        end else begin
          rep_cnt <= rep_inc;
        end
      end
    end
  end

  assign events = rise | (rep_fire ? {{(NUM_KEYS-HEX_KEYS){1'b0}}, deb[HEX_KEYS-1:0]} : '0);
`else
  assign events = rise;
`endif

  assign push      = |events;
  assign push_code = lowest_key(events);
  assign key_valid = !empty;
  assign pop       = key_valid && key_ready;
  assign drop      = push && full && !pop;

  // Sticky overflow; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) overflow <= 1'b0;
    else if (drop) overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

  keypad_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH($bits(key_code_t))
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(push_code),
    .pop      (pop),
    .full     (full),
    .empty    (empty),
    .head     (key_code)
  );

endmodule

// File: tb/tb_keypad_encoder.sv
// Bench for keypad_encoder: directed scenarios plus random presses, checked
// by a queue scoreboard fed from a reference model of the key rules.
// The auto-repeat scenario runs only when KEYPAD_AUTOREPEAT_EN is defined.
module tb_keypad_encoder;

  localparam int D     = 4;
  localparam int DEPTH = 4;
  localparam int RDLY  = 3;
  localparam int RRATE = 2;

  logic        clk;
  logic        rst;
  logic [19:0] pb;
  logic        key_valid;
  logic [4:0]  key_code;
  logic        key_ready;
  logic        key_held;
  logic        overflow;
  logic        ovf_clr;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int          exp_q[$];
  int          seen_q[$];
  logic [19:0] pb_log[$];
  int          cyc = 0;
  int          occ = 0;
  logic [19:0] m_samp = '0;
  logic [19:0] m_deb = '0;
  logic [19:0] s_now;
  logic [19:0] new_deb;
  bit          m_ovf = 0;
  bit          pend_valid = 0;
  int          pend_code = 0;
  bit          m_pop;
  bit          m_drop;
  int          rcount = 0;
  bit          rrep = 0;
  int          valid_cycles = 0;
  bit          held_seen = 0;

  keypad_encoder #(
    .DEBOUNCE_CYCLES(D),
    .FIFO_DEPTH     (DEPTH),
    .REPEAT_DELAY   (RDLY),
    .REPEAT_RATE    (RRATE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pb       (pb),
    .key_valid(key_valid),
    .key_code (key_code),
    .key_ready(key_ready),
    .key_held (key_held),
    .overflow (overflow),
    .ovf_clr  (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: pb is seen two edges late, sampled every D edges, a key
  // toggles after two agreeing samples, and its press is queued on the next edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc = 0; occ = 0; m_samp = '0; m_deb = '0; m_ovf = 0;
      pend_valid = 0; rcount = 0; rrep = 0;
      pb_log.delete();
      exp_q.delete();
    end else begin
      cyc++;
      pb_log.push_back(pb);
      if (pb_log.size() > 3) void'(pb_log.pop_front());
      m_pop  = (occ > 0) && key_ready;
      m_drop = 0;
      if (pend_valid) begin
        if (occ < DEPTH || m_pop) begin
          exp_q.push_back(pend_code);
          occ++;
        end else begin
          m_drop = 1;
        end
      end
      if (m_drop) m_ovf = 1;
      else if (ovf_clr) m_ovf = 0;
      if (m_pop) occ--;
      pend_valid = 0;
      if (cyc % D == 0) begin
        s_now   = (pb_log.size() >= 3) ? pb_log[0] : '0;
        new_deb = m_deb;
        for (int i = 0; i < 20; i++)
          if (s_now[i] == m_samp[i]) new_deb[i] = s_now[i];
        for (int i = 19; i >= 0; i--)
          if (new_deb[i] && !m_deb[i]) begin pend_valid = 1; pend_code = i; end
`ifdef KEYPAD_AUTOREPEAT_EN
        if (new_deb != m_deb || m_deb[19:16] != 0 || $countones(m_deb[15:0]) != 1) begin
          rcount = 0; rrep = 0;
        end else begin
          rcount++;
          if (rcount == (rrep ? RRATE : RDLY)) begin
            for (int i = 0; i < 16; i++) if (m_deb[i]) pend_code = i;
            pend_valid = 1; rcount = 0; rrep = 1;
          end
        end
`endif
        m_deb  = new_deb;
        m_samp = s_now;
      end
    end
  end

  // Monitor: compares outputs mid-cycle and retires expected codes on each handshake.
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      checkOutput("key_valid", int'(key_valid), int'(occ > 0));
      checkOutput("key_held", int'(key_held), int'(m_deb != 0));
      checkOutput("overflow", int'(overflow), int'(m_ovf));
      if (key_held) held_seen = 1;
      if (key_valid) begin
        valid_cycles++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_event: got code %0d, expected no event at %0t", key_code, $time);
        end else begin
          checkOutput("key_code", int'(key_code), exp_q[0]);
          if (key_ready) begin
            void'(exp_q.pop_front());
            seen_q.push_back(int'(key_code));
          end
        end
      end
    end
  end

  // Drive a button pattern for a number of cycles, optionally jittering the handshake inputs.
  task automatic applyStimulus(input logic [19:0] pattern, input int cycles, input bit rand_ctl);
    pb = pattern;
    for (int i = 0; i < cycles; i++) begin
      if (rand_ctl) begin
        key_ready = ($urandom_range(3) != 0);
        ovf_clr   = ($urandom_range(19) == 0);
      end
      @(negedge clk);
    end
    ovf_clr = 1'b0;
  endtask

  task automatic pressRelease(input int k);
    applyStimulus(20'(1) << k, 24, 0);
    applyStimulus('0, 24, 0);
  endtask

  initial begin
    logic [19:0] pat;
    int exp36[4];
    exp36 = '{1, 4, 7, 10};
    rst = 1'b1; pb = '0; key_ready = 1'b1; ovf_clr = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_key_valid", int'(key_valid), 0);
    checkOutput("rst_key_code", int'(key_code), 0);
    checkOutput("rst_key_held", int'(key_held), 0);
    checkOutput("rst_overflow", int'(overflow), 0);
    rst = 1'b0;
    applyStimulus('0, 10, 0);

    $display("[TB] single press of key 5");
    seen_q.delete(); valid_cycles = 0;
    applyStimulus(20'h00020, 40, 0);
    applyStimulus('0, 40, 0);
    checkOutput("k5_events", seen_q.size(), 1);
    if (seen_q.size() > 0) checkOutput("k5_code", seen_q[0], 5);
    checkOutput("k5_valid_cycles", valid_cycles, 1);

    $display("[TB] bouncing key 3");
    seen_q.delete(); held_seen = 0;
    if ((cyc + 1) % 2 == 0) @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      pb = ((i / 3) % 2 == 0) ? 20'h00008 : 20'h0;
      @(negedge clk);
    end
    applyStimulus('0, 30, 0);
    checkOutput("bounce_events", seen_q.size(), 0);
    checkOutput("bounce_held_seen", int'(held_seen), 0);

    $display("[TB] simultaneous keys 2 and 9");
    seen_q.delete();
    applyStimulus(20'h00204, 40, 0);
    applyStimulus('0, 40, 0);
    checkOutput("dual_events", seen_q.size(), 1);
    if (seen_q.size() > 0) checkOutput("dual_code", seen_q[0], 2);
    checkOutput("dual_overflow", int'(overflow), 0);

    $display("[TB] FIFO fill with consumer stalled");
    seen_q.delete(); key_ready = 1'b0;
    pressRelease(1); pressRelease(4); pressRelease(7); pressRelease(10); pressRelease(11);
    checkOutput("stall_overflow", int'(overflow), 1);
    checkOutput("stall_head", int'(key_code), 1);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    @(negedge clk);
    checkOutput("ovf_cleared", int'(overflow), 0);
    key_ready = 1'b1;
    applyStimulus('0, 12, 0);
    checkOutput("drain_count", seen_q.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < seen_q.size()) checkOutput("drain_order", seen_q[i], exp36[i]);

`ifdef KEYPAD_AUTOREPEAT_EN
    $display("[TB] auto-repeat on key 12, none on key 16");
    seen_q.delete();
    applyStimulus(20'h01000, 80, 0);
    applyStimulus('0, 40, 0);
    checkOutput("rep_count_ge8", int'(seen_q.size() >= 8), 1);
    foreach (seen_q[i]) checkOutput("rep_code", seen_q[i], 12);
    seen_q.delete();
    applyStimulus(20'h10000, 80, 0);
    applyStimulus('0, 40, 0);
    checkOutput("ctrl_events", seen_q.size(), 1);
    if (seen_q.size() > 0) checkOutput("ctrl_code", seen_q[0], 16);
`endif

    $display("[TB] random presses");
    for (int n = 0; n < 30; n++) begin
      pat = 20'(1) << $urandom_range(19);
      if ($urandom_range(3) == 0) pat |= 20'(1) << $urandom_range(19);
      if ($urandom_range(5) == 0) applyStimulus(pat, $urandom_range(1, 6), 1);
      applyStimulus(pat, $urandom_range(12, 40), 1);
      applyStimulus('0, $urandom_range(12, 32), 1);
    end
    key_ready = 1'b1; ovf_clr = 1'b1;
    applyStimulus('0, 20, 0);

    $display("[TB] reset with events queued");
    seen_q.delete(); key_ready = 1'b0;
    pressRelease(1); pressRelease(2); pressRelease(3);
    applyStimulus(20'h00001, 24, 0);
    #3 rst = 1'b1;
    #1 checkOutput("async_rst_valid", int'(key_valid), 0);
    checkOutput("async_rst_code", int'(key_code), 0);
    @(negedge clk);
    @(negedge clk);
    key_ready = 1'b1;
    rst = 1'b0;
    applyStimulus(20'h00001, 40, 0);
    checkOutput("post_rst_events", seen_q.size(), 1);
    if (seen_q.size() > 0) checkOutput("post_rst_code", seen_q[0], 0);
    applyStimulus('0, 40, 0);

    checkOutput("final_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/keypad_encoder.md
KEYPAD_ENCODER -- requirements
Module: keypad_encoder

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 100000, meaning clk cycles between debounce sample ticks (minimum 2).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, meaning key-event queue depth (power of two, 2..16).
REQ-003 The block SHALL have parameter REPEAT_DELAY, default 50, meaning sample ticks a hex key is held before the first auto-repeat.
REQ-004 The block SHALL have parameter REPEAT_RATE, default 10, meaning sample ticks between subsequent auto-repeats.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state is clocked on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port pb, input, 20 bits: raw, asynchronous push-buttons; [15:0] are hex keys 0-F, [19:16] are control keys.
REQ-008 The block SHALL have port key_valid, output, 1 bit: the head event is present.
REQ-009 The block SHALL have port key_code, output, 5 bits: head event code, 0-19 equal to the button index.
REQ-010 The block SHALL have port key_ready, input, 1 bit: the consumer (fpga input module) accepts the head event.
REQ-011 The block SHALL have port key_held, output, 1 bit: at least one debounced button is down.
REQ-012 The block SHALL have port overflow, output, 1 bit: sticky flag, set when an event is dropped.
REQ-013 The block SHALL have port ovf_clr, input, 1 bit: synchronous clear of overflow.

Function
REQ-014 Each pb bit SHALL pass through a 2-flop synchronizer before any other logic.
REQ-015 One shared counter SHALL generate a 1-cycle tick every DEBOUNCE_CYCLES cycles, wrapping from DEBOUNCE_CYCLES-1 to 0.
REQ-016 On each tick, each synchronized bit SHALL be sampled; its debounced bit SHALL change only when two consecutive tick samples agree and differ from the current debounced value.
REQ-017 A press event SHALL be a 0->1 transition of a debounced bit, registered one cycle after that transition.
REQ-018 When several press events occur in the same cycle, the lowest index SHALL be enqueued and the others discarded, without setting overflow.
REQ-019 Events SHALL be enqueued in a FIFO_DEPTH-entry FIFO; key_valid=~empty and key_code=head.
REQ-020 A pop SHALL occur on a cycle with key_valid&&key_ready; key_code SHALL stay stable while key_valid&&!key_ready.
REQ-021 When the FIFO is full, a push SHALL be accepted only if a pop occurs in the same cycle; otherwise the event is dropped and overflow is set.
REQ-022 When ovf_clr and a drop coincide, overflow SHALL end set (set wins).
REQ-023 Latency: with the FIFO empty, key_valid SHALL rise exactly 2 cycles after the tick whose sample completes debounce.
REQ-024 key_held SHALL equal the OR of the debounced bits.
REQ-025 Release events SHALL NOT be enqueued.

Reset
REQ-026 While rst is high, the synchronizers, debounced bits, tick counter, FIFO pointers and the repeat counter SHALL be zero, and key_valid, key_code, key_held and overflow SHALL be 0.
REQ-027 rst asserted mid-operation SHALL discard all queued events immediately; buttons held through the release of rst SHALL produce a press event after debounce.

Configuration
REQ-028 With KEYPAD_AUTOREPEAT_EN defined, a hex key (0-15) held alone SHALL re-enqueue its code after REPEAT_DELAY ticks, then every REPEAT_RATE ticks until released.
REQ-029 With KEYPAD_AUTOREPEAT_EN defined, control keys SHALL never repeat, and any second press or release SHALL restart the repeat timer.
REQ-030 Without KEYPAD_AUTOREPEAT_EN, no repeat logic SHALL exist, and each press SHALL yield exactly one event.

Structure
REQ-031 Package keypad_pkg SHALL hold the key_code_t typedef (5-bit) and the constants KEY_ENTER=16, KEY_BACK=17, KEY_MODE=18, KEY_RUN=19 and NUM_KEYS=20.
REQ-032 The FIFO SHALL be a sub-module, keypad_fifo, parameterised by depth and width; debounce and encode logic remain in keypad_encoder.

Verification (DEBOUNCE_CYCLES=4, FIFO_DEPTH=4, REPEAT_DELAY=3, REPEAT_RATE=2)
REQ-033 The bench SHALL cover: pb[5] stable high, key_ready=1 -> one event key_code=5 with key_valid high for 1 cycle; no second event on release.
REQ-034 The bench SHALL cover: pb[3] toggling every 3 cycles for 40 cycles, then low -> no event, key_held stays 0.
REQ-035 The bench SHALL cover: pb[2] and pb[9] rising in the same cycle -> only code 2 queued, overflow=0.
REQ-036 The bench SHALL cover: key_ready=0 with presses of 1, 4, 7, A and B -> the FIFO holds 1, 4, 7, A, overflow=1, and key_code stays 1; after ovf_clr, overflow=0; then key_ready=1 -> 1, 4, 7, A popped in order.
REQ-037 The bench SHALL cover: KEYPAD_AUTOREPEAT_EN defined and pb[12] held 20 ticks -> codes 12 at the press, then at +3 ticks and every 2 ticks; pb[16] held -> a single 16.
REQ-038 The bench SHALL cover: rst pulsed with 3 events queued -> key_valid=0 asynchronously; pb[0] held across rst -> code 0 after debounce.
